seq_fixedpoint_angle_fold: RTL and testbench



---
 rtl/fixedpoint_const_pkg.sv | 19 +
 rtl/comb_FixedPointZoom.sv | 36 +++
 rtl/comb_fixedpoint_quadrant_fold.sv | 50 +++++
 rtl/seq_fixedpoint_angle_fold.sv | 136 +++++++++++++
 tb/tb_seq_fixedpoint_angle_fold.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fixedpoint_const_pkg.sv
// Purpose: shared constants and state type for the fixed-point angle folder.
//   PI2, PI, HALFPI, PI3_2 : signed Q4.28 reference angles. Each user rescales
//                            them to its working precision with comb_FixedPointZoom.
//   state_t                : sequencer states of seq_fixedpoint_angle_fold.
package fixedpoint_const_pkg;

   localparam logic signed [31:0] PI2    = 32'sh6487ED51;
   localparam logic signed [31:0] PI     = 32'sh3243F6A9;
   localparam logic signed [31:0] HALFPI = 32'sh1921FB54;
   localparam logic signed [31:0] PI3_2  = 32'sh4B65F1FD;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REDUCE = 2'd1,
      S_FOLD   = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/comb_FixedPointZoom.sv
// Purpose: combinational signed fixed-point rescale Q(IW.IF) -> Q(OW.OF).
//   Dropping fraction bits rounds to nearest, with ties going up (toward +inf).
//   Adding fraction bits zero-fills. Integer bits are sign-extended or truncated.
// Ports:
//   i_in  : signed Q(IW.IF) value
//   o_out : signed Q(OW.OF) value
module comb_FixedPointZoom #(
   parameter int IW = 4,
   parameter int IF = 28,
   parameter int OW = 4,
   parameter int OF = 12
) (
   input  logic signed [IW+IF-1:0] i_in,
   output logic signed [OW+OF-1:0] o_out
);
   localparam int MW = (IW > OW) ? IW : OW;
   localparam int MF = (IF > OF) ? IF : OF;
   // One spare integer bit absorbs the rounding increment.
   localparam int WX = MW + MF + 1;

   logic signed [WX-1:0] w_ext;
   logic signed [WX-1:0] w_rnd;

   assign w_ext = WX'(i_in) <<< (MF - IF);

   if (MF > OF) begin : g_rnd
      localparam logic signed [WX-1:0] HALF = WX'(1) <<< (MF - OF - 1);
      logic signed [WX-1:0] w_sum;
      assign w_sum = w_ext + HALF;
      assign w_rnd = w_sum >>> (MF - OF);
   end else begin : g_pass
      assign w_rnd = w_ext;
   end

   assign o_out = w_rnd[OW+OF-1:0];
endmodule

// File: rtl/comb_fixedpoint_quadrant_fold.sv
// Purpose: one-step fold of a reduced angle r in [0, 2pi) into [0, pi/2].
//   It also reports whether the sine result changes sign in that quadrant.
// Ports:
//   i_r        : reduced angle, signed Q(WII+1.WF)
//   i_halfpi, i_pi, i_pi3_2, i_pi2 : constants at Q(WII+1.WF)
//   i_halfpi_o : pi/2 at the output precision Q(4.WAF), used as saturation cap
//   o_t        : folded angle Q(4.WAF), rounded and capped at pi/2
//   o_q        : 1 when sin(r) = -sin(t)
module comb_fixedpoint_quadrant_fold #(
   parameter int WII = 4,
   parameter int WF  = 12,
   parameter int WAF = 12
) (
   input  logic signed [WII+WF:0]  i_r,
   input  logic signed [WII+WF:0]  i_halfpi,
   input  logic signed [WII+WF:0]  i_pi,
   input  logic signed [WII+WF:0]  i_pi3_2,
   input  logic signed [WII+WF:0]  i_pi2,
   input  logic signed [3+WAF:0]   i_halfpi_o,
   output logic        [3+WAF:0]   o_t,
   output logic                    o_q
);
   logic signed [WII+WF:0] w_t;
   logic signed [3+WAF:0]  w_tr;

   // r == pi/2 falls into the second branch and gives pi - pi/2 = pi/2 exactly.
   always_comb begin
      w_t = i_r;
      o_q = 1'b0;
      if (i_r < i_halfpi) begin
         w_t = i_r;
      end else if (i_r < i_pi) begin
         w_t = i_pi - i_r;
      end else if (i_r < i_pi3_2) begin
         w_t = i_r - i_pi;
         o_q = 1'b1;
      end else begin
         w_t = i_pi2 - i_r;
         o_q = 1'b1;
      end
   end

   comb_FixedPointZoom #(.IW(WII+1), .IF(WF), .OW(4), .OF(WAF)) u_round (
      .i_in (w_t),
      .o_out(w_tr)
   );

   // Rounding up can push a value just below pi/2 past the output pi/2 constant.
   assign o_t = (w_tr > i_halfpi_o) ? i_halfpi_o : w_tr;
endmodule

// File: rtl/seq_fixedpoint_angle_fold.sv
// Purpose: multi-cycle range reducer that feeds a [0, pi/2] sine core.
//   It takes an arbitrary signed angle and returns a folded angle plus a negate
//   flag, so that sin(x) = o_neg ? -sin(o_angle) : sin(o_angle).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_valid/i_ready   : input handshake. Only one angle is in flight.
//   i_angle           : signed Q(WII.WIF) angle in radians
//   o_valid/o_ready   : output handshake. The result is held until taken.
//   o_angle           : folded angle in [0, pi/2], Q(4.WAF)
//   o_neg             : negate the downstream sine result
module seq_fixedpoint_angle_fold
   import fixedpoint_const_pkg::*;
#(
   parameter int WII = 4,
   parameter int WIF = 8,
   parameter int WAF = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [WII+WIF-1:0] i_angle,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [4+WAF-1:0]   o_angle,
   output logic               o_neg
);
   localparam int WF = (WIF > WAF) ? WIF : WAF;
   localparam int W  = WII + 1 + WF;
   localparam int K  = (WII > 3) ? WII - 3 : 0;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam logic [KW-1:0] KINIT = KW'((K > 0) ? K - 1 : 0);

   logic signed [W-1:0]     w_c_pi2, w_c_pi, w_c_halfpi, w_c_pi3_2;
   logic signed [4+WAF-1:0] w_c_halfpi_o;
   logic signed [W-1:0]     w_x, w_abs, w_step;
   logic [4+WAF-1:0]        w_t;
   logic                    w_q;

   state_t                  r_state, w_state_nxt;
   logic signed [W-1:0]     r_r, w_r_nxt;
   logic                    r_s, w_s_nxt;
   logic [KW-1:0]           r_k, w_k_nxt;
   logic [4+WAF-1:0]        r_angle, w_angle_nxt;
   logic                    r_neg, w_neg_nxt;
   logic                    r_valid, w_valid_nxt;

   comb_FixedPointZoom #(.IW(4), .IF(28), .OW(WII+1), .OF(WF)) u_c_pi2 (.i_in(PI2), .o_out(w_c_pi2));
   comb_FixedPointZoom #(.IW(4), .IF(28), .OW(WII+1), .OF(WF)) u_c_pi (.i_in(PI), .o_out(w_c_pi));
   comb_FixedPointZoom #(.IW(4), .IF(28), .OW(WII+1), .OF(WF)) u_c_hpi (.i_in(HALFPI), .o_out(w_c_halfpi));
   comb_FixedPointZoom #(.IW(4), .IF(28), .OW(WII+1), .OF(WF)) u_c_p32 (.i_in(PI3_2), .o_out(w_c_pi3_2));
   comb_FixedPointZoom #(.IW(4), .IF(28), .OW(4), .OF(WAF)) u_c_hpo (.i_in(HALFPI), .o_out(w_c_halfpi_o));

   // The extra integer bit makes |most-negative input| representable exactly.
   comb_FixedPointZoom #(.IW(WII), .IF(WIF), .OW(WII+1), .OF(WF)) u_in (
      .i_in (i_angle),
      .o_out(w_x)
   );
   assign w_abs  = w_x[W-1] ? -w_x : w_x;
   assign w_step = w_c_pi2 <<< r_k;   // 2pi * 2^k

   comb_fixedpoint_quadrant_fold #(.WII(WII), .WF(WF), .WAF(WAF)) u_fold (
      .i_r       (r_r),
      .i_halfpi  (w_c_halfpi),
      .i_pi      (w_c_pi),
      .i_pi3_2   (w_c_pi3_2),
      .i_pi2     (w_c_pi2),
      .i_halfpi_o(w_c_halfpi_o),
      .o_t       (w_t),
      .o_q       (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_r     <= '0;
         r_s     <= 1'b0;
         r_k     <= '0;
         r_angle <= '0;
         r_neg   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_r     <= w_r_nxt;
         r_s     <= w_s_nxt;
         r_k     <= w_k_nxt;
         r_angle <= w_angle_nxt;
         r_neg   <= w_neg_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_r_nxt     = r_r;
      w_s_nxt     = r_s;
      w_k_nxt     = r_k;
      w_angle_nxt = r_angle;
      w_neg_nxt   = r_neg;
      w_valid_nxt = r_valid;
      i_ready     = (r_state == S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_r_nxt     = w_abs;
               w_s_nxt     = i_angle[WII+WIF-1];
               w_k_nxt     = KINIT;
               w_state_nxt = (K > 0) ? S_REDUCE : S_FOLD;
            end
         end
         // Conditional subtraction of 2pi*2^k, from the largest k down to 0.
         S_REDUCE: begin
            if (r_r >= w_step) w_r_nxt = r_r - w_step;
            if (r_k == '0) w_state_nxt = S_FOLD;
            else           w_k_nxt     = r_k - KW'(1);
         end
         S_FOLD: begin
            w_angle_nxt = w_t;
            w_neg_nxt   = (w_q ^ r_s) & (w_t != '0);
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (o_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_valid = r_valid;
   assign o_angle = r_angle;
   assign o_neg   = r_neg;
endmodule

// File: tb/tb_seq_fixedpoint_angle_fold.sv
// Purpose: self-checking bench for seq_fixedpoint_angle_fold (WII=4, WIF=8, WAF=12).
//   It runs directed vectors, a hold-off window, a reset in the middle of an
//   operation, and randomized angles scored against a plain-arithmetic model.
module tb_seq_fixedpoint_angle_fold;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [11:0] i_angle = '0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [15:0] o_angle;
   logic        o_neg;

   int checks = 0;
   int errors = 0;
   int c_pi, c_2pi, c_hpi, c_3pi2;

   always #5 clk = ~clk;

   seq_fixedpoint_angle_fold #(.WII(4), .WIF(8), .WAF(12)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_valid(i_valid),
      .i_ready(i_ready),
      .i_angle(i_angle),
      .o_valid(o_valid),
      .o_ready(o_ready),
      .o_angle(o_angle),
      .o_neg  (o_neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: |x| mod 2pi, then pick the quadrant and apply the sign rule.
   // All values are integers at 2^-12 resolution. With 12 fractional bits in
   // both the working and output formats, the output needs no rescaling.
   task automatic model(input logic [11:0] ang, output logic [15:0] ea, output logic en);
      int x, a, t, q, s;
      x = int'($signed(ang)) * 16;
      s = (x < 0) ? 1 : 0;
      a = (x < 0) ? -x : x;
      a = a % c_2pi;
      if (a < c_hpi)       begin t = a;          q = 0; end
      else if (a < c_pi)   begin t = c_pi - a;   q = 0; end
      else if (a < c_3pi2) begin t = a - c_pi;   q = 1; end
      else                 begin t = c_2pi - a;  q = 1; end
      if (t > c_hpi) t = c_hpi;
      ea = 16'(t);
      en = ((q ^ s) != 0) && (t != 0);
   endtask

   // Called at a negedge while the DUT is idle; returns at a negedge.
   task automatic xact(input logic [11:0] ang, input logic [15:0] ea, input logic en,
                       input int hold, input string tag);
      int n;
      i_angle = ang;
      i_valid = 1'b1;
      n = 0;
      while (!i_ready && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_accept"}, 32'(i_ready), 32'd1);
      @(negedge clk);
      i_valid = 1'b0;
      i_angle = 12'($urandom);
      n = 1;
      while (!o_valid && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_latency"}, 32'(n), 32'd3);
      chk({tag, "_angle"}, 32'(o_angle), 32'(ea));
      chk({tag, "_neg"}, 32'(o_neg), 32'(en));
      chk({tag, "_busy"}, 32'(i_ready), 32'd0);
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
         chk({tag, "_hold_angle"}, 32'(o_angle), 32'(ea));
         chk({tag, "_hold_neg"}, 32'(o_neg), 32'(en));
         chk({tag, "_hold_busy"}, 32'(i_ready), 32'd0);
      end
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      chk({tag, "_drop_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(i_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] ea;
      logic        en;
      logic [11:0] ang;
      c_pi   = $rtoi(3.14159265358979 * 4096.0 + 0.5);
      c_2pi  = $rtoi(6.28318530717959 * 4096.0 + 0.5);
      c_hpi  = $rtoi(1.57079632679490 * 4096.0 + 0.5);
      c_3pi2 = $rtoi(4.71238898038469 * 4096.0 + 0.5);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_angle", 32'(o_angle), 32'd0);
      chk("rst_o_neg", 32'(o_neg), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_i_ready", 32'(i_ready), 32'd1);

      // o_ready without o_valid does nothing
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      chk("idle_oready_valid", 32'(o_valid), 32'd0);
      chk("idle_oready_ready", 32'(i_ready), 32'd1);

      // Directed vectors with hand-derived results
      xact(12'h100, 16'h1000, 1'b0, 0, "one");
      xact(12'h200, 16'h1244, 1'b0, 0, "two");
      xact(12'hF00, 16'h1000, 1'b1, 0, "neg_one");
      xact(12'h700, 16'h0B78, 1'b0, 0, "seven");
      xact(12'h400, 16'h0DBC, 1'b1, 10, "four_hold");
      xact(12'h000, 16'h0000, 1'b0, 0, "zero");
      xact(12'hFFF, 16'h0010, 1'b1, 0, "tiny_neg");

      // Reset while REDUCE is active discards the angle
      i_angle = 12'h800;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 32'(i_ready), 32'd1);
      chk("midrst_valid", 32'(o_valid), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("midrst_no_result", 32'(o_valid), 32'd0);
      end
      xact(12'h800, 16'h16CC, 1'b1, 0, "min_neg");

      // Randomized angles against the model
      for (int i = 0; i < 40; i++) begin
         ang = 12'($urandom_range(0, 4095));
         model(ang, ea, en);
         xact(ang, ea, en, $urandom_range(0, 3), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
